// File: rtl/avmm_sum_reader.sv
// avmm_sum_reader: Avalon-MM read initiator that streams a block of 32-bit words
// from SDRAM and accumulates their wrapping 32-bit sum. The CPU programs it
// through a small CSR slave. Reads of the result stall until the block is done.
//
// Ports:
//   clk_i                  system clock, rising edge
//   rst_i                  synchronous active-high reset
//   slave_address_i [1:0]  CSR word: 0 start/result, 1 source byte address, 2 word count
//   slave_read_i           CSR read request
//   slave_write_i          CSR write request
//   slave_writedata_i      CSR write data
//   slave_readdata_o       CSR read data (combinational, 0 when no read)
//   slave_waitrequest_o    stalls any CSR access while a run is in progress
//   master_address_o       word-aligned byte address of the current read
//   master_read_o          read request
//   master_readdata_i      returned word
//   master_readdatavalid_i master_readdata_i valid this cycle
//   master_waitrequest_i   slave not accepting the current read
module avmm_sum_reader #(
  parameter int unsigned MaxOutstanding = 4  // 1..15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  slave_address_i,
  input  logic        slave_read_i,
  input  logic        slave_write_i,
  input  logic [31:0] slave_writedata_i,
  output logic [31:0] slave_readdata_o,
  output logic        slave_waitrequest_o,
  output logic [31:0] master_address_o,
  output logic        master_read_o,
  input  logic [31:0] master_readdata_i,
  input  logic        master_readdatavalid_i,
  input  logic        master_waitrequest_i
);

  localparam int unsigned OutW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       src_q, src_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       sum_q, sum_d;
  logic [31:0]       issued_q, issued_d;
  logic [31:0]       received_q, received_d;
  logic [OutW-1:0]   out_q, out_d;

  logic busy;
  logic can_issue;
  logic accept;
  logic ret;

  assign busy      = (state_q != StIdle);
  assign can_issue = (state_q == StIssue) && (out_q < OutW'(MaxOutstanding));
  assign accept    = can_issue && !master_waitrequest_i;
  // Returns only count while a run is active; stray pulses in idle are dropped.
  assign ret       = busy && master_readdatavalid_i;

  // Address only advances on acceptance, so it is held while the slave stalls.
  assign master_read_o       = can_issue;
  assign master_address_o    = src_q + {issued_q[29:0], 2'b00};
  assign slave_waitrequest_o = busy && (slave_read_i || slave_write_i);

  always_comb begin
    slave_readdata_o = 32'h0;
    if (slave_read_i && !busy) begin
      case (slave_address_i)
        2'd0:    slave_readdata_o = sum_q;
        2'd1:    slave_readdata_o = src_q;
        2'd2:    slave_readdata_o = count_q;
        default: slave_readdata_o = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    count_d    = count_q;
    sum_d      = sum_q;
    issued_d   = issued_q;
    received_d = received_q;
    out_d      = out_q;

    unique case (state_q)
      StIdle: begin
        if (slave_write_i) begin
          case (slave_address_i)
            2'd0: begin
              sum_d      = 32'h0;
              issued_d   = 32'h0;
              received_d = 32'h0;
              out_d      = '0;
              // An empty block completes immediately without touching the bus.
              if (count_q != 32'h0) state_d = StIssue;
            end
            2'd1:    src_d   = {slave_writedata_i[31:2], 2'b00};
            2'd2:    count_d = slave_writedata_i;
            default: ;
          endcase
        end
      end

      StIssue, StDrain: begin
        if (accept) issued_d = issued_q + 32'd1;
        if (ret) begin
          sum_d      = sum_q + master_readdata_i;
          received_d = received_q + 32'd1;
        end
        // Accept and return in the same cycle leave the count unchanged.
        out_d = out_q + {{(OutW-1){1'b0}}, accept} - {{(OutW-1){1'b0}}, ret};

        if ((state_q == StIssue) && accept && (issued_d == count_q)) state_d = StDrain;
        if ((state_q == StDrain) && (received_d == count_q)) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      src_q      <= 32'h0;
      count_q    <= 32'h0;
      sum_q      <= 32'h0;
      issued_q   <= 32'h0;
      received_q <= 32'h0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      out_q      <= out_d;
    end
  end

endmodule

// File: tb/tb_avmm_sum_reader.sv
// Bench for avmm_sum_reader: a table of block reads (fixed and randomized) run against
// a latency/stall-configurable memory responder, with expected addresses and sums
// computed directly from the block description, plus reset and mid-run reset sequences.
module tb_avmm_sum_reader;

  localparam int unsigned MaxOut = 4;
  localparam int Bound = 2000;

  logic        clk;
  logic        rst;
  logic [1:0]  s_addr;
  logic        s_rd;
  logic        s_wr;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic        s_wait;
  logic [31:0] m_addr;
  logic        m_rd;
  logic [31:0] m_rdata;
  logic        m_valid;
  logic        m_wait;

  avmm_sum_reader #(
    .MaxOutstanding(MaxOut)
  ) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .slave_address_i        (s_addr),
    .slave_read_i           (s_rd),
    .slave_write_i          (s_wr),
    .slave_writedata_i      (s_wdata),
    .slave_readdata_o       (s_rdata),
    .slave_waitrequest_o    (s_wait),
    .master_address_o       (m_addr),
    .master_read_o          (m_rd),
    .master_readdata_i      (m_rdata),
    .master_readdatavalid_i (m_valid),
    .master_waitrequest_i   (m_wait)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] src;
    int          count;
    int          lat;
    int          wpct;
    int          sidx;
    int          slen;
    logic [31:0] base;
    logic [31:0] step;
    bit          rnd;
    logic [31:0] exp_sum;
    bit          has_exp;
    bit          tput;
    int          maxo;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Responder controls, written by the main sequence only.
  int          run_id = 0;
  bit          resp_en = 1'b0;
  int          lat = 1;
  int          wait_pct = 0;
  int          stall_idx = -1;
  int          stall_len = 0;
  logic [31:0] words [64];
  bit          man_valid = 1'b0;
  logic [31:0] man_data = 32'h0;

  // Responder observations, written by the responder only.
  logic [31:0] acc_addr[$];
  int          n_acc = 0;
  int          n_ret = 0;
  int          n_out = 0;
  int          max_out = 0;
  int          hold_err = 0;
  int          stall_seen = 0;
  int          stall_ctr = 0;
  int          first_acc = 0;
  int          last_acc = 0;

  // Memory responder: all decisions made just after the falling edge.
  initial begin
    int          cyc;
    int          seen_id;
    int          due_q[$];
    logic [31:0] dat_q[$];
    bit          pend_acc;
    bit          pend_ret;
    bit          prev_stalled;
    logic [31:0] prev_addr;
    cyc = 0; seen_id = 0; pend_acc = 0; pend_ret = 0; prev_stalled = 0; prev_addr = 0;
    m_valid = 1'b0; m_wait = 1'b0; m_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (pend_acc) begin
        if (n_acc == 0) first_acc = cyc;
        last_acc = cyc;
        acc_addr.push_back(prev_addr);
        due_q.push_back(cyc + lat - 1);
        dat_q.push_back(words[n_acc % 64]);
        n_acc++;
        n_out++;
      end
      if (pend_ret) begin
        n_ret++;
        n_out--;
      end
      if (n_out > max_out) max_out = n_out;
      if (run_id != seen_id) begin
        seen_id = run_id;
        acc_addr.delete();
        due_q.delete();
        dat_q.delete();
        n_acc = 0; n_ret = 0; n_out = 0; max_out = 0;
        hold_err = 0; stall_seen = 0; stall_ctr = 0; first_acc = 0; last_acc = 0;
      end
      if (!resp_en || rst) begin
        due_q.delete();
        dat_q.delete();
        n_out = 0;
        m_wait = 1'b0;
        m_valid = man_valid;
        m_rdata = man_data;
      end else begin
        m_wait = (int'($urandom_range(99, 0)) < wait_pct) ||
                 (n_acc == stall_idx && stall_ctr < stall_len);
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
          m_valid = 1'b1;
          m_rdata = dat_q.pop_front();
          void'(due_q.pop_front());
        end else begin
          m_valid = 1'b0;
          m_rdata = 32'hDEADBEEF;
        end
      end
      #1;
      if (prev_stalled && !(m_rd && m_addr == prev_addr)) hold_err++;
      if (resp_en && m_rd && n_acc == stall_idx) stall_seen++;
      if (resp_en && m_rd && m_wait && n_acc == stall_idx) stall_ctr++;
      pend_acc     = resp_en && !rst && m_rd && !m_wait;
      pend_ret     = resp_en && !rst && m_valid;
      prev_stalled = resp_en && !rst && m_rd && m_wait;
      prev_addr    = m_addr;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    s_addr = a; s_wr = 1'b1; s_wdata = d;
    #1;
    while (s_wait && n < Bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("csr_write_timeout", 32'(n >= Bound), 32'h0);
    @(negedge clk);
    s_wr = 1'b0;
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d, output int st);
    int n;
    n = 0;
    @(negedge clk);
    s_addr = a; s_rd = 1'b1;
    #1;
    while (s_wait && n < Bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("csr_read_timeout", 32'(n >= Bound), 32'h0);
    d = s_rdata;
    st = n;
    @(negedge clk);
    s_rd = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] d;
    logic [31:0] exp_sum;
    logic [31:0] src_al;
    int          st;
    int          n;
    src_al = {v.src[31:2], 2'b00};
    for (int i = 0; i < 64; i++) words[i] = v.rnd ? $urandom() : v.base + v.step * 32'(i);
    exp_sum = 32'h0;
    for (int i = 0; i < v.count; i++) exp_sum = exp_sum + words[i];
    if (v.has_exp) exp_sum = v.exp_sum;
    lat = v.lat; wait_pct = v.wpct; stall_idx = v.sidx; stall_len = v.slen;
    resp_en = 1'b1;
    run_id++;

    csr_write(2'd1, v.src);
    csr_write(2'd2, 32'(v.count));
    csr_read(2'd1, d, st);
    check({tag, ":src_readback"}, d, src_al);
    csr_read(2'd2, d, st);
    check({tag, ":count_readback"}, d, 32'(v.count));
    csr_write(2'd0, 32'h0);
    #3;
    check({tag, ":first_cycle_read"}, 32'(m_rd), 32'(v.count > 0));
    if (v.count > 0) check({tag, ":first_cycle_addr"}, m_addr, src_al);

    csr_read(2'd0, d, st);
    check({tag, ":sum"}, d, exp_sum);
    check({tag, ":result_stalled"}, 32'(st > 0), 32'(v.count > 0));
    check({tag, ":reads_issued"}, 32'(acc_addr.size()), 32'(v.count));
    n = (acc_addr.size() < v.count) ? acc_addr.size() : v.count;
    for (int i = 0; i < n; i++)
      check($sformatf("%s:addr[%0d]", tag, i), acc_addr[i], src_al + 32'(4 * i));
    check({tag, ":returns"}, 32'(n_ret), 32'(v.count));
    check({tag, ":held_request"}, 32'(hold_err), 32'h0);
    check({tag, ":outstanding_limit"}, 32'(max_out <= MaxOut), 32'h1);
    if (v.maxo > 0) check({tag, ":outstanding_peak"}, 32'(max_out), 32'(v.maxo));
    if (v.slen > 0) check({tag, ":stall_cycles"}, 32'(stall_seen), 32'(v.slen + 1));
    if (v.tput) check({tag, ":back_to_back"}, 32'(last_acc - first_acc), 32'(v.count - 1));
  endtask

  initial begin
    vec_t        vecs[12];
    vec_t        post;
    logic [31:0] d;
    int          st;
    int          n;

    vecs[0] = '{src:32'h1000, count:4, lat:1, wpct:0, sidx:-1, slen:0, base:1, step:1,
                rnd:0, exp_sum:10, has_exp:1, tput:1, maxo:0};
    vecs[1] = '{src:32'h1000, count:4, lat:1, wpct:0, sidx:1, slen:3, base:1, step:1,
                rnd:0, exp_sum:10, has_exp:1, tput:0, maxo:0};
    vecs[2] = '{src:32'h2000, count:8, lat:10, wpct:0, sidx:-1, slen:0, base:32'hFFFFFFFF,
                step:0, rnd:0, exp_sum:32'hFFFFFFF8, has_exp:1, tput:0, maxo:4};
    vecs[3] = '{src:32'hFFFFFFF8, count:3, lat:2, wpct:0, sidx:-1, slen:0, base:5, step:0,
                rnd:0, exp_sum:15, has_exp:1, tput:0, maxo:0};
    vecs[4] = '{src:32'h123, count:5, lat:3, wpct:0, sidx:-1, slen:0, base:32'h100,
                step:32'h10, rnd:0, exp_sum:32'h5A0, has_exp:1, tput:0, maxo:0};
    vecs[5] = '{src:32'h3000, count:0, lat:1, wpct:0, sidx:-1, slen:0, base:9, step:0,
                rnd:0, exp_sum:0, has_exp:1, tput:0, maxo:0};
    for (int i = 6; i < 12; i++)
      vecs[i] = '{src:$urandom(), count:int'($urandom_range(20, 1)),
                  lat:int'($urandom_range(12, 1)), wpct:int'($urandom_range(50, 0)),
                  sidx:-1, slen:0, base:0, step:0, rnd:1, exp_sum:0, has_exp:0, tput:0,
                  maxo:0};
    post = '{src:32'h5000, count:1, lat:1, wpct:0, sidx:-1, slen:0, base:7, step:0,
             rnd:0, exp_sum:7, has_exp:1, tput:0, maxo:0};

    rst = 1'b1; s_addr = 2'd0; s_rd = 1'b0; s_wr = 1'b0; s_wdata = 32'h0;
    for (int i = 0; i < 64; i++) words[i] = 32'h0;
    repeat (3) @(negedge clk);
    #3;
    check("reset:master_read", 32'(m_rd), 32'h0);
    check("reset:master_address", m_addr, 32'h0);
    check("reset:slave_waitrequest", 32'(s_wait), 32'h0);
    check("reset:slave_readdata", s_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 3; a++) begin
      csr_read(2'(a), d, st);
      check($sformatf("reset:csr[%0d]", a), d, 32'h0);
      check($sformatf("reset:csr[%0d]_nostall", a), 32'(st), 32'h0);
    end

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        csr_read(2'd3, d, st);
        check("csr[3]_zero", d, 32'h0);
      end
    end

    // Reset in the middle of a 6-word run once two words have come back.
    for (int i = 0; i < 64; i++) words[i] = 32'h11;
    lat = 6; wait_pct = 0; stall_idx = -1; stall_len = 0; resp_en = 1'b1;
    run_id++;
    csr_write(2'd1, 32'h4000);
    csr_write(2'd2, 32'd6);
    csr_write(2'd0, 32'h0);
    n = 0;
    while (n_ret < 2 && n < Bound) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("midrst:two_returned", 32'(n_ret >= 2), 32'h1);
    @(negedge clk);
    rst = 1'b1; resp_en = 1'b0;
    @(negedge clk);
    #3;
    check("midrst:master_read_low", 32'(m_rd), 32'h0);
    @(negedge clk);
    rst = 1'b0; man_valid = 1'b1; man_data = 32'h55;
    @(negedge clk);
    @(negedge clk);
    man_valid = 1'b0;
    #3;
    check("midrst:idle_no_read", 32'(m_rd), 32'h0);
    csr_read(2'd0, d, st);
    check("midrst:sum_cleared", d, 32'h0);
    check("midrst:idle_nostall", 32'(st), 32'h0);
    run_vec(post, "postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/avmm_sum_reader.md
# avmm_sum_reader

Avalon-MM read initiator that streams a block of 32-bit words out of SDRAM and accumulates their wrapping sum. It sits inside the DNN accelerator system as a bus master facing the SDRAM controller's slave port, and is driven by the CPU through a small Avalon-MM CSR slave. CPU reads of the result stall until the block is done.

## Interface
- MAX_OUTSTANDING, 4: maximum accepted-but-unreturned master reads (1..15).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- slave_address  in  2  CSR word index: 0 = start/result, 1 = source byte address, 2 = word count.
- slave_read  in  1  CSR read request.
- slave_write  in  1  CSR write request.
- slave_writedata  in  32  CSR write data.
- slave_readdata  out  32  CSR read data; valid when slave_read=1 and slave_waitrequest=0.
- slave_waitrequest  out  1  stall of the current CSR access.
- master_address  out  32  byte address of the current read, word-aligned.
- master_read  out  1  read request.
- master_readdata  in  32  returned word.
- master_readdatavalid  in  1  master_readdata valid this cycle.
- master_waitrequest  in  1  slave not accepting the current read.

## Operation
- Registers: src (32b, bits [1:0] forced to 0), count (32b), sum (32b), issued, received, outstanding counters.
- CSR writes in IDLE: word 1 -> src; word 2 -> count; word 0 (any data) -> sum=0, issued=0, received=0, go to ISSUE (or stay IDLE with done if count==0).
- CSR reads: word 0 -> sum; word 1 -> src; word 2 -> count; word 3 -> 0.
- slave_waitrequest = 1 for any slave access (read or write, any address) while state != IDLE; 0 in IDLE. Stalled writes take effect once accepted in IDLE.
- States: IDLE, ISSUE, DRAIN.
  - IDLE: master_read=0; master_readdatavalid ignored.
  - ISSUE: master_read=1 while outstanding < MAX_OUTSTANDING; master_address = src + 4*issued (mod 2^32). Read accepted when master_read & !master_waitrequest: issued++, outstanding++. When the accepted read makes issued==count -> DRAIN.
  - DRAIN: master_read=0; wait until received==count -> IDLE.
- Held request: while master_waitrequest=1, master_address and master_read stay stable.
- Returns: on master_readdatavalid in ISSUE/DRAIN: sum += master_readdata (wrap mod 2^32), received++, outstanding--. Accept and return same cycle -> outstanding unchanged.
- Address wrap past 0xFFFFFFFC continues at 0x00000000.
- count==0 start: no master reads; sum=0; state stays IDLE.
- Write to word 0 while busy: stalled, then starts a new run after the current one completes.

## Timing
- Reset values: master_read=0, master_address=0, slave_waitrequest=0, slave_readdata=0, src=0, count=0, sum=0, all counters 0, state IDLE.
- Reset mid-run: next cycle IDLE, master_read=0; late master_readdatavalid pulses ignored; sum=0.
- Start write accepted in cycle N -> master_read=1 with address src in cycle N+1.
- Throughput: one accepted read per cycle with waitrequest low and outstanding < MAX_OUTSTANDING.
- Outstanding limit: with outstanding==MAX_OUTSTANDING, master_read=0 that cycle; a return in cycle M allows a new request in M+1.
- Last readdatavalid in cycle L -> state IDLE and updated sum visible in cycle L+1; a stalled CSR read of word 0 completes in L+1 returning the final sum.
- slave_readdata combinational from registers in IDLE; 0 when no read.

## Test plan
- Reset then CSR reads of words 0/1/2 -> 0,0,0 with slave_waitrequest=0; master_read=0.
- src=0x1000, count=4, memory model zero-latency readdatavalid next cycle, no waitrequest, words 1,2,3,4 -> addresses 0x1000,0x1004,0x1008,0x100C in 4 consecutive cycles; word 0 read stalls then returns 10.
- Same run with master_waitrequest high 3 cycles on 2nd read -> address 0x1004 held stable 4 cycles, sum still 10.
- count=8, responder latency 10 cycles, MAX_OUTSTANDING=4 -> never more than 4 accepted-unreturned reads; 8 returns of 0xFFFFFFFF -> sum 0xFFFFFFF8.
- src=0xFFFFFFF8, count=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; count=0 start -> no master_read, word 0 reads 0 without stall.
- rst asserted after 2 of 6 reads returned, then 2 late readdatavalids -> sum=0, state IDLE, master_read=0; new run of count=1 word 7 -> sum 7.
